// File: rtl/avmm_read_monitor.sv
// avmm_read_monitor
// Passive monitor for an Avalon-MM read port. It snoops accepted read
// commands and returned read beats. Every beat is stored in a capture buffer
// that either stops when full or overwrites the oldest entry. For each burst
// it measures the latency from command to first data, and keeps the last,
// minimum and maximum values. Several bursts may be outstanding at once.
//
// Ports
//   user_clk, user_resetn      clock, synchronous active-low reset
//   clear                      clears buffer pointer, statistics, sticky flags
//   wrap_mode                  0 = stop when full, 1 = overwrite oldest
//   amm_read/ready/burstcount  snooped command channel
//   amm_readdatavalid/readdata snooped response channel
//   rd_addr -> rd_data         buffer readout, one cycle latency
//   wr_ptr, beat_count, full   capture buffer state
//   overflow                   sticky: a beat was dropped or overwrote data
//   lat_valid, lat_last/min/max latency statistics
//   outstanding                commands accepted and not fully answered
//   cmd_overflow, orphan_beat  sticky error flags
module avmm_read_monitor #(
    parameter int DATA_WIDTH       = 128,
    parameter int DEPTH            = 4096,
    parameter int BURSTCOUNT_WIDTH = 7,
    parameter int CMD_DEPTH        = 16,
    parameter int LAT_WIDTH        = 16
) (
    input  logic                          user_clk,
    input  logic                          user_resetn,
    input  logic                          clear,
    input  logic                          wrap_mode,
    input  logic                          amm_read,
    input  logic                          amm_ready,
    input  logic [BURSTCOUNT_WIDTH-1:0]   amm_burstcount,
    input  logic                          amm_readdatavalid,
    input  logic [DATA_WIDTH-1:0]         amm_readdata,
    input  logic [$clog2(DEPTH)-1:0]      rd_addr,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH)-1:0]      wr_ptr,
    output logic [$clog2(DEPTH):0]        beat_count,
    output logic                          full,
    output logic                          overflow,
    output logic                          lat_valid,
    output logic [LAT_WIDTH-1:0]          lat_last,
    output logic [LAT_WIDTH-1:0]          lat_min,
    output logic [LAT_WIDTH-1:0]          lat_max,
    output logic [$clog2(CMD_DEPTH):0]    outstanding,
    output logic                          cmd_overflow,
    output logic                          orphan_beat
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CMD_DEPTH);
    localparam int BW = BURSTCOUNT_WIDTH;

    localparam logic [AW:0]          DEPTH_C     = (AW+1)'(DEPTH);
    localparam logic [CW:0]          CMD_DEPTH_C = (CW+1)'(CMD_DEPTH);
    localparam logic [AW-1:0]        A_ONE       = AW'(1);
    localparam logic [AW:0]          CNT_ONE     = (AW+1)'(1);
    localparam logic [CW-1:0]        C_ONE       = CW'(1);
    localparam logic [CW:0]          CC_ONE      = (CW+1)'(1);
    localparam logic [BW-1:0]        BC_ONE      = BW'(1);
    localparam logic [LAT_WIDTH-1:0] TS_ONE      = LAT_WIDTH'(1);

    // A burstcount of zero is interpreted as a single-beat burst.
    function automatic logic [BW-1:0] eff_bc(input logic [BW-1:0] bc);
        logic [BW-1:0] res;
        if (bc == '0) begin
            res = BC_ONE;
        end else begin
            res = bc;
        end
        return res;
    endfunction

    // Registers
    logic [LAT_WIDTH-1:0]  r_ts;
    logic [LAT_WIDTH-1:0]  r_cmd_ts [CMD_DEPTH];
    logic [BW-1:0]         r_cmd_bc [CMD_DEPTH];
    logic [CW-1:0]         r_cmd_wptr;
    logic [CW-1:0]         r_cmd_rptr;
    logic [CW:0]           r_cmd_cnt;
    logic [BW-1:0]         r_remain;
    logic [DATA_WIDTH-1:0] r_buf [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW:0]           r_beat_count;
    logic                  r_full;
    logic                  r_overflow;
    logic                  r_lat_valid;
    logic [LAT_WIDTH-1:0]  r_lat_last;
    logic [LAT_WIDTH-1:0]  r_lat_min;
    logic [LAT_WIDTH-1:0]  r_lat_max;
    logic                  r_cmd_overflow;
    logic                  r_orphan_beat;

    // Wires
    logic                  w_accept;
    logic                  w_cmd_full;
    logic                  w_cmd_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_first;
    logic                  w_orphan;
    logic [BW-1:0]         w_head_bc;
    logic [LAT_WIDTH-1:0]  w_lat;
    logic [BW-1:0]         w_remain_nxt;
    logic                  w_cap;
    logic                  w_write;

    // Command/beat matching and capture decisions for the current cycle.
    // The head entry is read before this cycle's push lands, so a command
    // accepted together with a beat is never matched to that beat.
    always_comb begin
        w_accept     = amm_read && amm_ready;
        w_cmd_full   = (r_cmd_cnt == CMD_DEPTH_C);
        w_cmd_empty  = (r_cmd_cnt == '0);
        w_push       = w_accept && !w_cmd_full;
        w_head_bc    = eff_bc(r_cmd_bc[r_cmd_rptr]);
        w_lat        = r_ts - r_cmd_ts[r_cmd_rptr];
        w_first      = 1'b0;
        w_pop        = 1'b0;
        w_orphan     = 1'b0;
        w_remain_nxt = r_remain;
        if (amm_readdatavalid) begin
            if (r_remain != '0) begin
                w_remain_nxt = r_remain - BC_ONE;
                w_pop        = (r_remain == BC_ONE) && !w_cmd_empty;
            end else if (!w_cmd_empty) begin
                w_first      = 1'b1;
                w_remain_nxt = w_head_bc - BC_ONE;
                w_pop        = (w_head_bc == BC_ONE);
            end else begin
                w_orphan     = 1'b1;
            end
        end else begin
            w_remain_nxt = r_remain;
        end
        // A beat in the clear cycle is not captured.
        w_cap   = amm_readdatavalid && !clear;
        w_write = w_cap && (!r_full || wrap_mode);
    end

    // Free-running timestamp.
    always_ff @(posedge user_clk) begin
        if (!user_resetn) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_ONE;
        end
    end

    // Command FIFO storage; contents are only meaningful below r_cmd_cnt.
    always_ff @(posedge user_clk) begin
        if (w_push) begin
            r_cmd_ts[r_cmd_wptr] <= r_ts;
            r_cmd_bc[r_cmd_wptr] <= amm_burstcount;
        end
    end

    // Command FIFO pointers and remaining-beat counter (unaffected by clear).
    always_ff @(posedge user_clk) begin
        if (!user_resetn) begin
            r_cmd_wptr <= '0;
            r_cmd_rptr <= '0;
            r_cmd_cnt  <= '0;
            r_remain   <= '0;
        end else begin
            r_remain <= w_remain_nxt;
            if (w_push) begin
                r_cmd_wptr <= r_cmd_wptr + C_ONE;
            end
            if (w_pop) begin
                r_cmd_rptr <= r_cmd_rptr + C_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_cmd_cnt <= r_cmd_cnt + CC_ONE;
                2'b01:   r_cmd_cnt <= r_cmd_cnt - CC_ONE;
                default: r_cmd_cnt <= r_cmd_cnt;
            endcase
        end
    end

    // Latency statistics and sticky error flags.
    always_ff @(posedge user_clk) begin
        if (!user_resetn || clear) begin
            r_lat_valid    <= 1'b0;
            r_lat_last     <= '0;
            r_lat_min      <= '1;
            r_lat_max      <= '0;
            r_cmd_overflow <= 1'b0;
            r_orphan_beat  <= 1'b0;
        end else begin
            r_lat_valid <= w_first;
            if (w_first) begin
                r_lat_last <= w_lat;
                if (w_lat < r_lat_min) begin
                    r_lat_min <= w_lat;
                end
                if (w_lat > r_lat_max) begin
                    r_lat_max <= w_lat;
                end
            end
            if (w_orphan) begin
                r_orphan_beat <= 1'b1;
            end
            if (w_accept && w_cmd_full) begin
                r_cmd_overflow <= 1'b1;
            end
        end
    end

    // Capture buffer write pointer, fill level and overflow flag.
    always_ff @(posedge user_clk) begin
        if (!user_resetn || clear) begin
            r_wr_ptr     <= '0;
            r_beat_count <= '0;
            r_full       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + A_ONE;
            end
            if (w_cap && !r_full) begin
                r_beat_count <= r_beat_count + CNT_ONE;
                r_full       <= ((r_beat_count + CNT_ONE) == DEPTH_C);
            end
            if (w_cap && r_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Capture buffer memory (no reset, contents undefined after reset).
    always_ff @(posedge user_clk) begin
        if (w_write) begin
            r_buf[r_wr_ptr] <= amm_readdata;
        end
    end

    // Registered readout port; a same-cycle write returns the old word.
    always_ff @(posedge user_clk) begin
        if (!user_resetn) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_buf[rd_addr];
        end
    end

    assign rd_data      = r_rd_data;
    assign wr_ptr       = r_wr_ptr;
    assign beat_count   = r_beat_count;
    assign full         = r_full;
    assign overflow     = r_overflow;
    assign lat_valid    = r_lat_valid;
    assign lat_last     = r_lat_last;
    assign lat_min      = r_lat_min;
    assign lat_max      = r_lat_max;
    assign outstanding  = r_cmd_cnt;
    assign cmd_overflow = r_cmd_overflow;
    assign orphan_beat  = r_orphan_beat;

endmodule
